// File: rtl/div_mod_top_if.sv
// Request/result bundle for the divide/modulo unit.
// Ports: dividend, divisor, mode, valid_input (request); valid_output, final_output (result).
interface div_mod_top_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             mode;
    logic             valid_input;
    logic             valid_output;
    logic [WIDTH-1:0] final_output;

    modport master (
        output dividend, divisor, mode, valid_input,
        input  valid_output, final_output
    );

    modport slave (
        input  dividend, divisor, mode, valid_input,
        output valid_output, final_output
    );
endinterface

// File: rtl/div_mod_top.sv
// Multi-cycle radix-2 restoring divide/modulo unit, one result per request.
// Ports: clk, reset (async active-low), bus (div_mod_top_if.slave).
// Build option: DIV_SIGNED_EN selects two's complement operands (truncating division).
module div_mod_top #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    div_mod_top_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_mode;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic             w_load;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_dvd_in;
    logic [WIDTH-1:0] w_dvs_in;

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // Divide magnitudes; signs are restored when the result is loaded.
    assign w_dvd_in = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_dvs_in = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    assign w_dvd_in = bus.dividend;
    assign w_dvs_in = bus.divisor;
`endif

    assign w_accept = (r_state == S_IDLE) && bus.valid_input;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // Partial remainder needs one extra bit after the shift.
    assign w_shift  = {r_rem, r_quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_dvsr});
    // When w_ge holds the true difference is below 2^WIDTH.
    assign w_diff   = w_shift[WIDTH-1:0] - r_dvsr;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.valid_input) w_next = S_CALC;
            S_CALC:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_load = (r_state == S_DONE);
`ifdef DIV_SIGNED_EN
        w_res = r_mode ? (r_neg_r ? -r_rem : r_rem)
                       : (r_neg_q ? -r_quo : r_quo);
`else
        w_res = r_mode ? r_rem : r_quo;
`endif
    end

    // Datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvsr  <= '0;
            r_mode  <= 1'b0;
            r_out   <= '0;
            r_valid <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_out <= w_res;
            end
            if (w_accept) begin
                r_cnt  <= '0;
                r_rem  <= '0;
                r_quo  <= w_dvd_in;
                r_dvsr <= w_dvs_in;
                r_mode <= bus.mode;
`ifdef DIV_SIGNED_EN
                r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                r_neg_r <= bus.dividend[WIDTH-1];
`endif
            end else if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], w_ge};
            end
        end
    end

    assign bus.valid_output = r_valid;
    assign bus.final_output = r_out;
endmodule

// File: tb/tb_div_mod_top.sv
// Self-checking bench for div_mod_top (unsigned build, WIDTH=16).
// Ports: none; drives the unit through div_mod_top_if.
module tb_div_mod_top;
    localparam int W   = 16;
    localparam int LAT = W + 2;
    localparam int WIN = 40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    div_mod_top_if #(.WIDTH(W)) bus ();

    div_mod_top #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         mode;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[10];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                          input logic mode, output logic [W-1:0] res,
                          output int lat, output int pulses,
                          output logic [W-1:0] last_out);
        @(negedge clk);
        bus.dividend    = dvd;
        bus.divisor     = dvs;
        bus.mode        = mode;
        bus.valid_input = 1'b1;
        @(posedge clk);
        res    = '0;
        lat    = -1;
        pulses = 0;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (c == 1) bus.valid_input = 1'b0;
            if (bus.valid_output === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    res = bus.final_output;
                end
            end
        end
        last_out = bus.final_output;
    endtask

    logic [W-1:0] res;
    logic [W-1:0] last_out;
    int lat;
    int pulses;

    initial begin
        vecs[0] = '{16'd100,   16'd7,     1'b0, 16'd14,    "div_100_7"};
        vecs[1] = '{16'd100,   16'd7,     1'b1, 16'd2,     "mod_100_7"};
        vecs[2] = '{16'd65535, 16'd1,     1'b0, 16'd65535, "div_max_1"};
        vecs[3] = '{16'd1234,  16'd0,     1'b0, 16'hFFFF,  "div_by_0"};
        vecs[4] = '{16'd1234,  16'd0,     1'b1, 16'd1234,  "mod_by_0"};
        vecs[5] = '{16'd9,     16'd4,     1'b1, 16'd1,     "mod_9_4"};
        vecs[6] = '{16'd0,     16'd5,     1'b0, 16'd0,     "div_0_5"};
        vecs[7] = '{16'd65535, 16'd65535, 1'b1, 16'd0,     "mod_max_max"};
        vecs[8] = '{16'd7,     16'd9,     1'b0, 16'd0,     "div_small"};
        vecs[9] = '{16'd40000, 16'd300,   1'b1, 16'd100,   "mod_40000_300"};

        reset           = 1'b0;
        bus.dividend    = '0;
        bus.divisor     = '0;
        bus.mode        = 1'b0;
        bus.valid_input = 1'b0;

        // Reset held for five cycles, with a request strobe present.
        bus.valid_input = 1'b1;
        bus.dividend    = 16'd55;
        bus.divisor     = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_valid", 32'(bus.valid_output), 32'd0);
            check("reset_out",   32'(bus.final_output), 32'd0);
        end
        bus.valid_input = 1'b0;
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, vecs[i].mode, res, lat, pulses,
                   last_out);
            check({vecs[i].name, "_res"},    32'(res),      32'(vecs[i].exp));
            check({vecs[i].name, "_lat"},    32'(lat),      32'(LAT));
            check({vecs[i].name, "_pulses"}, 32'(pulses),   32'd1);
            check({vecs[i].name, "_hold"},   32'(last_out), 32'(vecs[i].exp));
        end

        // Busy: a second request during CALC must be ignored.
        @(negedge clk);
        bus.dividend    = 16'd100;
        bus.divisor     = 16'd7;
        bus.mode        = 1'b0;
        bus.valid_input = 1'b1;
        @(posedge clk);
        res    = '0;
        lat    = -1;
        pulses = 0;
        for (int c = 1; c <= WIN; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                bus.dividend    = 16'd50;
                bus.divisor     = 16'd5;
                bus.valid_input = 1'b1;
            end else begin
                bus.valid_input = 1'b0;
            end
            if (bus.valid_output === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = c;
                    res = bus.final_output;
                end
            end
        end
        check("busy_res",    32'(res),    32'd14);
        check("busy_lat",    32'(lat),    32'(LAT));
        check("busy_pulses", 32'(pulses), 32'd1);

        // Abort: reset three cycles into CALC.
        @(negedge clk);
        bus.dividend    = 16'd100;
        bus.divisor     = 16'd7;
        bus.mode        = 1'b0;
        bus.valid_input = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_input = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_valid", 32'(bus.valid_output), 32'd0);
            check("abort_out",   32'(bus.final_output), 32'd0);
        end
        reset  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.valid_output === 1'b1) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);

        run_op(16'd9, 16'd4, 1'b1, res, lat, pulses, last_out);
        check("post_abort_res",    32'(res),    32'd1);
        check("post_abort_lat",    32'(lat),    32'(LAT));
        check("post_abort_pulses", 32'(pulses), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
